// File: rtl/pc_pkg.sv
// Shared definitions for the program-sequencing unit: opcode encoding and its width.
package pc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NEXT   = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4
  } pc_op_t;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for pc_seq.
// A push is ignored when the stack is full, and a pop is ignored when it is empty.
module pc_ret_stack #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] mem_q [2**IDX_W];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              doPush;
  logic              doPop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(STACK_DEPTH));
  assign doPush = push && !full;
  assign doPop  = pop && !empty && !doPush;
  assign top    = mem_q[IDX_W'(count_q - CNT_W'(1))];

  always_comb begin
    count_d = count_q;
    if (doPush) begin
      count_d = count_q + CNT_W'(1);
    end else if (doPop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The entries themselves need no reset: the depth count alone decides which ones are valid.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[IDX_W'(count_q)] <= din;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-sequencing unit: next-PC selection, call/return stack, and a sticky fault flag.
// Optional macro PC_TRAP_EN redirects a stack overflow or underflow to TRAP_VEC.
module pc_seq
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned OFF_W       = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_VEC   = 0,
  parameter int unsigned TRAP_VEC    = 32'h0000_FFF0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [OP_W-1:0]   op,
  input  logic              cond,
  input  logic [ADDR_W-1:0] target,
  input  logic [OFF_W-1:0]  offset,
  output logic [ADDR_W-1:0] pc,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              fault
);

`ifdef PC_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ResetAddr = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] TrapAddr  = ADDR_W'(TRAP_VEC);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              fault_q;
  logic              fault_d;
  logic [ADDR_W-1:0] pcInc;
  logic [ADDR_W-1:0] brOff;
  logic [ADDR_W-1:0] stackTop;
  logic              push;
  logic              pop;

  assign pcInc = pc_q + ADDR_W'(1);
  assign brOff = ADDR_W'($signed(offset));

  pc_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pcInc),
    .top   (stackTop),
    .empty (stack_empty),
    .full  (stack_full)
  );

  // A stall leaves every default in place, so all state holds while en is low.
  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (en) begin
      case (op)
        OP_JUMP:   pc_d = target;
        OP_BRANCH: pc_d = cond ? (pc_q + brOff) : pcInc;
        OP_CALL: begin
          if (stack_full) begin
            fault_d = 1'b1;
            pc_d    = TrapEn ? TrapAddr : target;
          end else begin
            push = 1'b1;
            pc_d = target;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            fault_d = 1'b1;
            pc_d    = TrapEn ? TrapAddr : pcInc;
          end else begin
            pop  = 1'b1;
            pc_d = stackTop;
          end
        end
        default:   pc_d = pcInc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= ResetAddr;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign pc    = pc_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq.
// A high-level model predicts the state after each edge and queues it; a monitor pops and compares.
module tb_pc_seq;

  localparam int ADDR_W    = 16;
  localparam int OFF_W     = 8;
  localparam int DEPTH     = 4;
  localparam int RESET_VEC = 0;
  localparam int TRAP_VEC  = 'hFFF0;
  localparam int MASK      = (1 << ADDR_W) - 1;
`ifdef PC_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              empty;
    logic              full;
    logic              fault;
  } obs_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              en = 1'b0;
  logic [2:0]        op = 3'd0;
  logic              cond = 1'b0;
  logic [ADDR_W-1:0] target = '0;
  logic [OFF_W-1:0]  offset = '0;
  logic [ADDR_W-1:0] pc;
  logic              stack_empty;
  logic              stack_full;
  logic              fault;

  obs_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: the PC as a plain integer and the return stack as a queue.
  int   mPc = 0;
  int   mStack[$];
  bit   mFault = 1'b0;

  pc_seq #(
    .ADDR_W      (ADDR_W),
    .OFF_W       (OFF_W),
    .STACK_DEPTH (DEPTH),
    .RESET_VEC   (RESET_VEC),
    .TRAP_VEC    (TRAP_VEC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .op          (op),
    .cond        (cond),
    .target      (target),
    .offset      (offset),
    .pc          (pc),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input bit r, input bit e, input logic [2:0] o,
                               input bit c, input int t, input int off);
    obs_t exp;
    @(negedge clk);
    reset  = r;
    en     = e;
    op     = o;
    cond   = c;
    target = ADDR_W'(t);
    offset = OFF_W'(off);
    if (r) begin
      mPc    = RESET_VEC;
      mFault = 1'b0;
      mStack.delete();
    end else if (e) begin
      case (o)
        3'd1: mPc = t & MASK;
        3'd2: mPc = c ? (mPc + int'($signed(offset))) & MASK : (mPc + 1) & MASK;
        3'd3: begin
          if (mStack.size() == DEPTH) begin
            mFault = 1'b1;
            mPc    = TRAP ? TRAP_VEC : (t & MASK);
          end else begin
            mStack.push_back((mPc + 1) & MASK);
            mPc = t & MASK;
          end
        end
        3'd4: begin
          if (mStack.size() == 0) begin
            mFault = 1'b1;
            mPc    = TRAP ? TRAP_VEC : ((mPc + 1) & MASK);
          end else begin
            mPc = mStack.pop_back();
          end
        end
        default: mPc = (mPc + 1) & MASK;
      endcase
    end
    exp.pc    = ADDR_W'(mPc);
    exp.empty = (mStack.size() == 0);
    exp.full  = (mStack.size() == DEPTH);
    exp.fault = mFault;
    expQ.push_back(exp);
  endtask

  task automatic checkOutput();
    obs_t exp;
    obs_t act;
    exp = expQ.pop_front();
    act = '{pc: pc, empty: stack_empty, full: stack_full, fault: fault};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL state @%0t: actual pc=%h empty=%b full=%b fault=%b, required pc=%h empty=%b full=%b fault=%b",
               $time, act.pc, act.empty, act.full, act.fault, exp.pc, exp.empty, exp.full, exp.fault);
    end
  endtask

  // Monitor: the DUT presents a new registered state after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput();
    end
  end

  initial begin
    int drain;
    int o;
    // Reset dominates en/op, then a stall must freeze everything.
    applyStimulus(1, 1, 3'd1, 0, 'h1234, 0);
    applyStimulus(1, 1, 3'd1, 0, 'h1234, 0);
    repeat (3) applyStimulus(0, 0, 3'd0, 0, 0, 0);
    // Wrap through all-ones, then an absolute jump.
    applyStimulus(0, 1, 3'd1, 0, 'hFFFE, 0);
    applyStimulus(0, 1, 3'd0, 0, 0, 0);
    applyStimulus(0, 1, 3'd0, 0, 0, 0);
    applyStimulus(0, 1, 3'd1, 0, 'h0100, 0);
    // Taken negative branch, not-taken branch, zero-offset hold.
    applyStimulus(0, 1, 3'd1, 0, 'h0010, 0);
    applyStimulus(0, 1, 3'd2, 1, 0, 'hFC);
    applyStimulus(0, 1, 3'd2, 0, 0, 'hFC);
    applyStimulus(0, 1, 3'd2, 1, 0, 0);
    applyStimulus(0, 1, 3'd2, 1, 0, 'h7F);
    // Nested calls and returns.
    applyStimulus(0, 1, 3'd1, 0, 20, 0);
    applyStimulus(0, 1, 3'd3, 0, 40, 0);
    applyStimulus(0, 1, 3'd3, 0, 60, 0);
    applyStimulus(0, 1, 3'd4, 0, 0, 0);
    applyStimulus(0, 1, 3'd4, 0, 0, 0);
    // Overflow with five consecutive calls, stall after fault, then reset.
    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 3'd3, 0, i * 'h100, 0);
    applyStimulus(0, 0, 3'd4, 0, 0, 0);
    applyStimulus(1, 0, 3'd0, 0, 0, 0);
    // Underflow, then reset mid-operation.
    applyStimulus(0, 1, 3'd4, 0, 0, 0);
    applyStimulus(0, 1, 3'd0, 0, 0, 0);
    applyStimulus(1, 1, 3'd3, 0, 'h55, 0);
    // Call immediately followed by return, plus unused opcodes.
    applyStimulus(0, 1, 3'd3, 0, 'h0300, 0);
    applyStimulus(0, 1, 3'd4, 0, 0, 0);
    for (int i = 5; i < 8; i++) applyStimulus(0, 1, 3'(i), 0, 'h7777, 0);
    // Randomized traffic weighted toward stack activity.
    for (int i = 0; i < 600; i++) begin
      o = $urandom_range(0, 9);
      if (o == 8) o = 3;
      if (o == 9) o = 4;
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 9) != 0, 3'(o),
                    1'($urandom), $urandom_range(0, MASK), $urandom_range(0, 255));
    end
    drain = 0;
    while (expQ.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (expQ.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: actual %0d pending, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-sequencing unit that replaces the load-only program counter. It holds the current instruction address and advances it every enabled cycle. It applies absolute jumps, conditional relative branches, and subroutine call/return through an internal return-address stack. It sits between the control decoder (`op`, `cond`, `target`, `offset`) and instruction memory (`pc`).

## Interface
- `ADDR_W`, 16: width of `pc`, `target` and stored return addresses.
- `OFF_W`, 8: width of the signed branch offset.
- `STACK_DEPTH`, 4: number of return-address entries; must be ≥ 1.
- `RESET_VEC`, 0: value loaded into `pc` on reset.
- `TRAP_VEC`, 16'hFFF0 (truncated to `ADDR_W`): fault target, used only with `PC_TRAP_EN`.

Ports (name, direction, width, meaning):
- `clk` — in — 1 — sole clock; all state updates on its rising edge.
- `reset` — in — 1 — synchronous, active-high.
- `en` — in — 1 — advance enable; 0 freezes all state (stall).
- `op` — in — 3 — operation code (encodings below).
- `cond` — in — 1 — branch condition, sampled only for BRANCH.
- `target` — in — `ADDR_W` — absolute destination for JUMP/CALL.
- `offset` — in — `OFF_W` — signed two's-complement displacement for BRANCH.
- `pc` — out — `ADDR_W` — current address, registered.
- `stack_empty` — out — 1 — high when depth count = 0.
- `stack_full` — out — 1 — high when depth count = `STACK_DEPTH`.
- `fault` — out — 1 — sticky; set on stack overflow or underflow.

## Operation
- Opcode encodings: NEXT=0, JUMP=1, BRANCH=2, CALL=3, RET=4. Codes 5–7 behave as NEXT.
- Reset dominates `en` and `op`:
  - `pc`←`RESET_VEC`, depth count←0, `fault`←0.
  - Hence `stack_empty`=1 and `stack_full`=0.
  - Stack contents are don't-care.
- `en`=0: `pc`, the stack, the depth count and `fault` all hold; `op` is ignored.
- `en`=1, per op:
  - NEXT: `pc`←`pc`+1.
  - JUMP: `pc`←`target`.
  - BRANCH: if `cond`=1, `pc`←`pc`+sign-extended `offset`; otherwise `pc`←`pc`+1. An offset of 0 with `cond`=1 holds `pc`, which is legal.
  - CALL: push `pc`+1, then `pc`←`target`, depth count +1.
  - RET: `pc`←top-of-stack, depth count −1.
- Arithmetic is modulo 2^`ADDR_W`. There is no overflow flag: `pc`+1 from all-ones wraps to 0, and negative branches below 0 wrap.
- Boundary behaviour without `PC_TRAP_EN`:
  - CALL while full: `pc`←`target`, the push is dropped, the depth count is unchanged, `fault`←1.
  - RET while empty: `pc`←`pc`+1, the depth count stays 0, `fault`←1.
- `fault` clears only on reset.

## Timing
- All outputs are registered. An op presented in cycle N is visible on `pc` in cycle N+1.
- `stack_empty` and `stack_full` reflect the depth count after the same edge.
- Back-to-back CALL/RET on consecutive cycles is supported at full rate with no bubble. RET in the cycle immediately after CALL returns the address pushed by that CALL.
- No combinational path exists from any input to any output.

## Configuration
- `PC_TRAP_EN` defined: on CALL-while-full or RET-while-empty, `pc`←`TRAP_VEC`, `fault`←1, and the depth count is unchanged. All other behaviour is identical.
- `PC_TRAP_EN` undefined: the boundary behaviour listed under Operation applies, and `TRAP_VEC` is unused.

## Structure
- Shared package `pc_pkg`:
  - `pc_op_t` 3-bit enum (NEXT, JUMP, BRANCH, CALL, RET).
  - `OP_W` = 3.
- One sub-module, `pc_ret_stack`, parametrised by `ADDR_W` and `STACK_DEPTH`:
  - LIFO with `push`, `pop`, `din`, `top`, `empty`, `full`, and the same `clk`/`reset`.
  - Ignores a push when full and a pop when empty.
- `pc_seq` owns the next-PC mux, the `fault` register and the trap logic.

## Test plan
- Reset/stall: assert `reset` with `en`=1 and `op`=JUMP → `pc`=0, `stack_empty`=1, `fault`=0. Then hold `en`=0 for 3 cycles with `op`=NEXT → `pc` stays 0.
- Sequencing and wrap: from `pc`=16'hFFFE, two NEXT ops → `pc`=FFFF, then 0000. JUMP with `target`=16'h0100 → `pc`=0100 next cycle.
- Branch: at `pc`=16'h0010, BRANCH with `offset`=8'hFC (−4) and `cond`=1 → 000C. BRANCH with `cond`=0 → 000D.
- Nested calls: at `pc`=20, CALL `target` 40 → `pc`=40. At 40, CALL `target` 60 → `pc`=60. RET → 41. RET → 21. `stack_empty` returns to 1.
- Overflow: with `STACK_DEPTH`=4, issue 5 consecutive CALLs → `stack_full`=1 after the 4th, `fault`=1 after the 5th. Without the macro, `pc`=5th `target`; with `PC_TRAP_EN`, `pc`=`TRAP_VEC`.
- Underflow and reset mid-operation: RET on an empty stack → `fault`=1, `pc`=`pc`+1 (or `TRAP_VEC` with `PC_TRAP_EN`). Then `reset` → `fault`=0, `pc`=`RESET_VEC`.
